// File: rtl/sideband_pkg.sv
// Shared types and helpers for the sideband event monitor.
package sideband_pkg;

  // Default geometry used to size the reference event record.
  localparam int SB_CH_N_DEF   = 8;
  localparam int SB_TS_W_DEF   = 32;
  localparam int SB_CHAN_W_DEF = (SB_CH_N_DEF > 1) ? $clog2(SB_CH_N_DEF) : 1;
  localparam int SB_MODE_W     = 2;

  // Per-channel edge mode encoding as seen on mode_i.
  typedef enum logic [SB_MODE_W-1:0] {
    SB_OFF  = 2'b00,
    SB_RISE = 2'b01,
    SB_FALL = 2'b10,
    SB_BOTH = 2'b11
  } sb_edge_mode_e;

  // One queued event: channel, direction (1 = rising) and detection timestamp.
  typedef struct packed {
    logic [SB_CHAN_W_DEF-1:0] chan;
    logic                     is_rise;
    logic [SB_TS_W_DEF-1:0]   ts;
  } sb_evt_t;

  // True when a raw edge is enabled by the channel's mode.
  function automatic logic sb_edge_qual(input sb_edge_mode_e mode,
                                        input logic          rise,
                                        input logic          fall);
    return (rise && (mode == SB_RISE || mode == SB_BOTH)) ||
           (fall && (mode == SB_FALL || mode == SB_BOTH));
  endfunction

endpackage

// File: rtl/sideband_evt_fifo.sv
// First-word fall-through event FIFO with registered storage.
// Push and pop in the same cycle are accepted even when full.
module sideband_evt_fifo
  import sideband_pkg::*;
#(
  parameter int  DEPTH  = 8,
  parameter type item_t = sb_evt_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  item_t push_data_i,
  input  logic  pop_i,
  output item_t pop_data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  item_t       mem [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Head of queue is presented directly; forced to zero while empty.
  assign pop_data_o = empty_o ? '0 : mem[rd_ptr_q[AW-1:0]];

  // Read/write pointers with wrap bit to tell full from empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Payload storage.
  // NOTE: the storage array has no reset; empty/full come from the pointers
  // only and the output mux hides stale contents, so clearing it buys nothing.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/sideband_event_mon.sv
// Multi-channel sideband event monitor: synchronises raw lines, detects
// mode-qualified edges, counts/flags them and queues timestamped events.
module sideband_event_mon
  import sideband_pkg::*;
#(
  parameter  int CH_N        = 8,
  parameter  int SYNC_STAGES = 2,
  parameter  int CNT_W       = 16,
  parameter  int TS_W        = 32,
  parameter  int FIFO_DEPTH  = 8,
  localparam int CHAN_W      = (CH_N > 1) ? $clog2(CH_N) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [CH_N-1:0]       sb_i,
  input  logic [2*CH_N-1:0]     mode_i,
  input  logic [CH_N-1:0]       cnt_clr_i,
  input  logic [CH_N-1:0]       sticky_clr_i,
  input  logic                  ovf_clr_i,
  output logic [CH_N-1:0]       sb_sync_o,
  output logic [CH_N-1:0]       sticky_o,
  output logic [CH_N*CNT_W-1:0] cnt_o,
  output logic                  ovf_o,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [CHAN_W-1:0]     evt_chan_o,
  output logic                  evt_edge_o,
  output logic [TS_W-1:0]       evt_ts_o
);

  localparam int ARM_CYC = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_CYC + 1);

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic              is_rise;
    logic [TS_W-1:0]   ts;
  } evt_t;

  logic [CH_N-1:0]  sync_q [SYNC_STAGES];
  logic [CH_N-1:0]  sync_lvl, prev_q;
  logic [CH_N-1:0]  rises, falls, qual_edge;
  logic [ARM_W-1:0] arm_cnt_q;
  logic             armed;
  logic [TS_W-1:0]  ts_q;

  logic [CH_N-1:0]  pend_vld_q, pend_rise_q;
  logic [TS_W-1:0]  pend_ts_q [CH_N];
  logic [CNT_W-1:0] cnt_q [CH_N];
  logic [CH_N-1:0]  sticky_q;
  logic             ovf_q, ovf_hit;

  logic [CH_N-1:0]  grant_oh, pushed;
  logic             push_req, push_ok;
  evt_t             push_item, head_item;
  logic             fifo_full, fifo_empty, fifo_pop;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign armed    = (arm_cnt_q == ARM_W'(ARM_CYC));

  // Synchroniser chain for the raw asynchronous lines.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample the pre-edge values, which is what makes the shift chain work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= sb_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Previous level, arm window counter and free-running timestamp.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q    <= '0;
      arm_cnt_q <= '0;
      ts_q      <= '0;
    end else begin
      prev_q <= sync_lvl;
      if (!armed) arm_cnt_q <= arm_cnt_q + ARM_W'(1);
      ts_q <= ts_q + TS_W'(1);
    end
  end

  // Raw edges qualified by the per-channel mode; masked until armed.
  // NOTE: each combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rises     = sync_lvl & ~prev_q;
    falls     = ~sync_lvl & prev_q;
    qual_edge = '0;
    for (int c = 0; c < CH_N; c++) begin
      qual_edge[c] = armed &
                     sb_edge_qual(sb_edge_mode_e'(mode_i[2*c +: 2]), rises[c], falls[c]);
    end
  end

  // Fixed-priority arbiter: lowest pending channel index wins the FIFO slot.
  always_comb begin
    grant_oh  = '0;
    push_req  = 1'b0;
    push_item = '0;
    for (int c = CH_N - 1; c >= 0; c--) begin
      if (pend_vld_q[c]) begin
        grant_oh          = '0;
        grant_oh[c]       = 1'b1;
        push_req          = 1'b1;
        push_item.chan    = CHAN_W'(c);
        push_item.is_rise = pend_rise_q[c];
        push_item.ts      = pend_ts_q[c];
      end
    end
  end

  // A pop in the same cycle frees a slot for the winner even at full.
  assign fifo_pop = ~fifo_empty & evt_ready_i;
  assign push_ok  = push_req & (~fifo_full | fifo_pop);
  assign pushed   = push_ok ? grant_oh : '0;
  assign ovf_hit  = |(qual_edge & pend_vld_q & ~pushed);

  // Per-channel pending slot: a held event is never overwritten by a newer one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_vld_q  <= '0;
      pend_rise_q <= '0;
      for (int c = 0; c < CH_N; c++) pend_ts_q[c] <= '0;
    end else begin
      for (int c = 0; c < CH_N; c++) begin
        if (qual_edge[c] && (!pend_vld_q[c] || pushed[c])) begin
          pend_vld_q[c]  <= 1'b1;
          pend_rise_q[c] <= rises[c];
          pend_ts_q[c]   <= ts_q;
        end else if (pushed[c]) begin
          pend_vld_q[c] <= 1'b0;
        end
      end
    end
  end

  // Saturating counters (clear wins) and sticky flags (set wins).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= '0;
      for (int c = 0; c < CH_N; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < CH_N; c++) begin
        if (cnt_clr_i[c])                       cnt_q[c] <= '0;
        else if (qual_edge[c] && cnt_q[c] != '1) cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        if (qual_edge[c])         sticky_q[c] <= 1'b1;
        else if (sticky_clr_i[c]) sticky_q[c] <= 1'b0;
      end
    end
  end

  // Overflow flag: a new drop in the same cycle beats the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        ovf_q <= 1'b0;
    else if (ovf_hit)   ovf_q <= 1'b1;
    else if (ovf_clr_i) ovf_q <= 1'b0;
  end

  sideband_evt_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .item_t (evt_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push_ok),
    .push_data_i (push_item),
    .pop_i       (fifo_pop),
    .pop_data_o  (head_item),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Flatten counters onto the output bus, channel 0 in the LSBs.
  always_comb begin
    cnt_o = '0;
    for (int c = 0; c < CH_N; c++) cnt_o[c*CNT_W +: CNT_W] = cnt_q[c];
  end

  assign sb_sync_o   = sync_lvl;
  assign sticky_o    = sticky_q;
  assign ovf_o       = ovf_q;
  assign evt_valid_o = ~fifo_empty;
  assign evt_chan_o  = head_item.chan;
  assign evt_edge_o  = head_item.is_rise;
  assign evt_ts_o    = head_item.ts;

endmodule

// File: tb/tb_sideband_event_mon.sv
// Self-checking bench for sideband_event_mon with an event scoreboard.
module tb_sideband_event_mon;

  localparam int CH_N        = 16;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int TS_W        = 32;
  localparam int FIFO_DEPTH  = 8;
  localparam int CHAN_W      = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [CH_N-1:0]       sb_i;
  logic [2*CH_N-1:0]     mode_i;
  logic [CH_N-1:0]       cnt_clr_i, sticky_clr_i;
  logic                  ovf_clr_i;
  logic [CH_N-1:0]       sb_sync_o, sticky_o;
  logic [CH_N*CNT_W-1:0] cnt_o;
  logic                  ovf_o, evt_valid_o, evt_ready_i, evt_edge_o;
  logic [CHAN_W-1:0]     evt_chan_o;
  logic [TS_W-1:0]       evt_ts_o;

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic              is_rise;
    logic [TS_W-1:0]   ts;
  } exp_t;

  exp_t            exp_q[$];
  int              n_checks = 0;
  int              n_errors = 0;
  logic [TS_W-1:0] cyc;

  sideband_event_mon #(
    .CH_N(CH_N), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W),
    .TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sb_i(sb_i), .mode_i(mode_i),
    .cnt_clr_i(cnt_clr_i), .sticky_clr_i(sticky_clr_i), .ovf_clr_i(ovf_clr_i),
    .sb_sync_o(sb_sync_o), .sticky_o(sticky_o), .cnt_o(cnt_o), .ovf_o(ovf_o),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_chan_o(evt_chan_o),
    .evt_edge_o(evt_edge_o), .evt_ts_o(evt_ts_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference timestamp: cycles since reset release.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cyc <= '0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Called in the cycle a line toggles: detection happens SYNC_STAGES later.
  task automatic expect_evt(input int ch, input logic rise);
    exp_t e;
    e.chan    = CHAN_W'(ch);
    e.is_rise = rise;
    e.ts      = cyc + TS_W'(SYNC_STAGES);
    exp_q.push_back(e);
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return cnt_o[ch*CNT_W +: CNT_W];
  endfunction

  task automatic drain(input string tag);
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every transfer must match the oldest expected event.
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (rst_ni && evt_valid_o && evt_ready_i) begin
      if (exp_q.size() == 0) begin
        check("evt_unexpected", 64'(evt_valid_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("evt_chan", 64'(evt_chan_o), 64'(e.chan));
        check("evt_edge", 64'(evt_edge_o), 64'(e.is_rise));
        check("evt_ts",   64'(evt_ts_o),   64'(e.ts));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sb_i         = '0;
    sb_i[0]      = 1'b1;
    mode_i       = 32'h5555_55D5;  // all RISE, ch3 BOTH
    cnt_clr_i    = '0;
    sticky_clr_i = '0;
    ovf_clr_i    = 1'b0;
    evt_ready_i  = 1'b1;

    // Reset values, then a line held high through reset must not fire.
    tick(3);
    check("rst_valid",  64'(evt_valid_o), 64'd0);
    check("rst_cnt",    64'(cnt_o),       64'd0);
    check("rst_sticky", 64'(sticky_o),    64'd0);
    check("rst_ovf",    64'(ovf_o),       64'd0);
    check("rst_sync",   64'(sb_sync_o),   64'd0);
    rst_ni = 1'b1;
    tick(10);
    check("arm_sync0",  64'(sb_sync_o[0]), 64'd1);
    check("arm_valid",  64'(evt_valid_o),  64'd0);
    check("arm_cnt0",   64'(cnt_of(0)),    64'd0);
    check("arm_sticky", 64'(sticky_o),     64'd0);

    // Ch3 BOTH: 5-cycle pulse gives rise then fall, first event after S+2 edges.
    sb_i[3] = 1'b1;
    expect_evt(3, 1'b1);
    tick(SYNC_STAGES + 1);
    check("lat_early", 64'(evt_valid_o), 64'd0);
    tick(1);
    check("lat_valid", 64'(evt_valid_o), 64'd1);
    check("lat_chan",  64'(evt_chan_o),  64'd3);
    tick(1);
    sb_i[3] = 1'b0;
    expect_evt(3, 1'b0);
    tick(6);
    check("both_cnt3",    64'(cnt_of(3)),   64'd2);
    check("both_sticky3", 64'(sticky_o[3]), 64'd1);
    drain("drain_both");

    // Ch1 and ch6 rise together: ch1 first, ch6 the next cycle, same ts.
    sb_i[1] = 1'b1;
    sb_i[6] = 1'b1;
    expect_evt(1, 1'b1);
    expect_evt(6, 1'b1);
    tick(SYNC_STAGES + 2);
    check("arb_first",  64'(evt_chan_o), 64'd1);
    tick(1);
    check("arb_valid2", 64'(evt_valid_o), 64'd1);
    check("arb_second", 64'(evt_chan_o),  64'd6);
    drain("drain_arb");

    // Back-pressure: 9 edges fill the FIFO and leave ch15 pending.
    evt_ready_i = 1'b0;
    for (int c = 7; c < 16; c++) begin
      sb_i[c] = 1'b1;
      expect_evt(c, 1'b1);
    end
    tick(12);
    check("full_valid", 64'(evt_valid_o), 64'd1);
    check("full_head",  64'(evt_chan_o),  64'd7);
    check("full_noovf", 64'(ovf_o),       64'd0);
    sb_i[15] = 1'b0;
    tick(2);
    sb_i[15] = 1'b1;
    tick(SYNC_STAGES + 2);
    check("ovf_set",   64'(ovf_o),     64'd1);
    check("ovf_cnt15", 64'(cnt_of(15)), 64'd2);
    evt_ready_i = 1'b1;
    drain("drain_full");
    check("ovf_sticky", 64'(ovf_o), 64'd1);
    ovf_clr_i = 1'b1;
    tick(1);
    ovf_clr_i = 1'b0;
    check("ovf_clr", 64'(ovf_o), 64'd0);

    // Counter saturation on ch2 (4-bit counter).
    for (int i = 0; i < 15; i++) begin
      sb_i[2] = 1'b1;
      expect_evt(2, 1'b1);
      tick(1);
      sb_i[2] = 1'b0;
      tick(1);
    end
    tick(4);
    check("sat_reach", 64'(cnt_of(2)), 64'hF);
    sb_i[2] = 1'b1;
    expect_evt(2, 1'b1);
    tick(1);
    sb_i[2] = 1'b0;
    tick(5);
    check("sat_hold", 64'(cnt_of(2)), 64'hF);
    drain("drain_sat");

    // Clear coincident with a detected edge: counter clears, sticky stays set.
    sb_i[2] = 1'b1;
    expect_evt(2, 1'b1);
    tick(SYNC_STAGES);
    cnt_clr_i[2]    = 1'b1;
    sticky_clr_i[2] = 1'b1;
    tick(1);
    cnt_clr_i[2]    = 1'b0;
    sticky_clr_i[2] = 1'b0;
    tick(2);
    check("clr_cnt2",    64'(cnt_of(2)),   64'd0);
    check("clr_sticky2", 64'(sticky_o[2]), 64'd1);
    sticky_clr_i[3] = 1'b1;
    tick(1);
    sticky_clr_i[3] = 1'b0;
    check("sticky_clr3", 64'(sticky_o[3]), 64'd0);
    drain("drain_clr");

    // Reset with events queued: everything clears at once, arm window restarts.
    evt_ready_i = 1'b0;
    sb_i[3] = 1'b1;
    sb_i[4] = 1'b1;
    sb_i[5] = 1'b1;
    tick(8);
    check("mid_queued", 64'(evt_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("mid_valid",  64'(evt_valid_o), 64'd0);
    check("mid_cnt",    64'(cnt_o),       64'd0);
    check("mid_sticky", 64'(sticky_o),    64'd0);
    check("mid_ovf",    64'(ovf_o),       64'd0);
    exp_q.delete();
    tick(2);
    rst_ni = 1'b1;
    evt_ready_i = 1'b1;
    tick(1);
    check("rearm_valid0", 64'(evt_valid_o), 64'd0);
    tick(10);
    check("rearm_valid1", 64'(evt_valid_o), 64'd0);
    check("rearm_cnt3",   64'(cnt_of(3)),   64'd0);
    check("rearm_sticky", 64'(sticky_o),    64'd0);
    check("rearm_sync",   64'(sb_sync_o),   64'(sb_i));
    sb_i[3] = 1'b0;
    expect_evt(3, 1'b0);
    drain("drain_rearm");
    check("rearm_cnt3b", 64'(cnt_of(3)), 64'd1);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
